// File: rtl/ifns_link_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifns_pkg
//  Description : Shared constants, FSM state type and helper function for the
//                IFNS link scheduler (chunk/codeword widths, chunk count).
//  Revision    : 1.0  initial release
// ============================================================================
package ifns_pkg;

    localparam int CHUNK_W = 5;   // data bits carried by one codeword
    localparam int CODE_W  = 7;   // wires on the IFNS-coded link

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of 5-bit chunks needed to carry a w-bit word.
    function automatic int nchunk(input int w);
        return (w + CHUNK_W - 1) / CHUNK_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifns_link_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifns_link_scheduler_if
//  Description : Bundle between the two requesters, the scheduler and the
//                downstream bus drivers.
//                  req0_*/req1_* : requester word valid/ready handshakes
//                  code_*        : codeword valid/ready stream with framing
//                master = requester/bus-driver side, slave = scheduler side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ifns_link_scheduler_if
    import ifns_pkg::*;
#(
    parameter int DATA_W = 20
);
    logic [DATA_W-1:0] req0_data;
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req1_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [CODE_W:1]   code_out;
    logic              code_valid;
    logic              code_ready;
    logic              code_sof;
    logic              code_eof;
    logic              code_src;

    modport master (
        output req0_data, req0_valid, req1_data, req1_valid, code_ready,
        input  req0_ready, req1_ready, code_out, code_valid,
               code_sof, code_eof, code_src
    );

    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid, code_ready,
        output req0_ready, req1_ready, code_out, code_valid,
               code_sof, code_eof, code_src
    );
endinterface
`default_nettype wire

// File: rtl/encoderIFNS_5di_core.sv
`default_nettype none
// ============================================================================
//  Module      : encoderIFNS_5di_core
//  Description : Combinational 5-bit to 7-wire IFNS encoder. The value is
//                written in a Fibonacci-weighted numeral system, wires
//                d7..d1 weighted 13,8,5,3,2,1,1, digits chosen greedily from
//                the top. Every value 0..31 is representable.
//                  i_data : 5-bit chunk
//                  o_code : codeword, [7:1] = d7..d1
//  Revision    : 1.0  initial release
// ============================================================================
module encoderIFNS_5di_core (
    input  wire logic [4:0] i_data,
    output logic      [7:1] o_code
);
    logic [5:0] w_rem;

    always_comb begin
        w_rem  = {1'b0, i_data};
        o_code = '0;
        if (w_rem >= 6'd13) begin o_code[7] = 1'b1; w_rem = w_rem - 6'd13; end
        if (w_rem >= 6'd8)  begin o_code[6] = 1'b1; w_rem = w_rem - 6'd8;  end
        if (w_rem >= 6'd5)  begin o_code[5] = 1'b1; w_rem = w_rem - 6'd5;  end
        if (w_rem >= 6'd3)  begin o_code[4] = 1'b1; w_rem = w_rem - 6'd3;  end
        if (w_rem >= 6'd2)  begin o_code[3] = 1'b1; w_rem = w_rem - 6'd2;  end
        if (w_rem >= 6'd1)  begin o_code[2] = 1'b1; w_rem = w_rem - 6'd1;  end
        if (w_rem >= 6'd1)  begin o_code[1] = 1'b1; end
    end
endmodule
`default_nettype wire

// File: rtl/ifns_link_scheduler_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ifns_rr_arb2
//  Description : Two-way round-robin grant (combinational). The pointer
//                (i_rr_last = last granted index) is kept by the parent.
//                  i_valid0/1      : request valids
//                  i_rr_last       : index granted most recently
//                  o_grant         : granted index
//                  o_grant_valid   : some request is being granted
//  Revision    : 1.0  initial release
// ============================================================================
module ifns_rr_arb2 (
    input  wire logic i_valid0,
    input  wire logic i_valid1,
    input  wire logic i_rr_last,
    output logic      o_grant,
    output logic      o_grant_valid
);
    always_comb begin
        o_grant_valid = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            o_grant = ~i_rr_last;   // tie: the one not served last time
        end else begin
            o_grant = i_valid1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/ifns_link_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ifns_link_scheduler
//  Description : Shares one 7-wire IFNS link between two requesters. Words
//                are round-robin arbitrated, split into 5-bit chunks (LSB
//                chunk first), encoded and streamed through a registered
//                valid/ready output stage with sof/eof/src framing.
//                  clock, rst : clock, synchronous active-high reset
//                  bus        : requester handshakes + codeword stream
//  Revision    : 1.0  initial release
// ============================================================================
module ifns_link_scheduler
    import ifns_pkg::*;
#(
    parameter int DATA_W = 20
) (
    input  wire logic           clock,
    input  wire logic           rst,
    ifns_link_scheduler_if.slave bus
);
    localparam int NCHUNK  = nchunk(DATA_W);
    localparam int SHIFT_W = CHUNK_W * NCHUNK;
    localparam int CIDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CIDX_W-1:0] c_LAST_IDX = CIDX_W'(NCHUNK - 1);

    state_t              r_state;
    logic [SHIFT_W-1:0]  r_shift;
    logic [CIDX_W-1:0]   r_chunk_idx;
    logic                r_src;
    logic                r_rr_last;
    logic [CODE_W:1]     r_code;
    logic                r_code_valid;
    logic                r_code_sof;
    logic                r_code_eof;
    logic                r_code_src;

    logic                w_grant;
    logic                w_grant_valid;
    logic                w_idle;
    logic                w_ready0;
    logic                w_ready1;
    logic                w_accept;
    logic [DATA_W-1:0]   w_word;
    logic [SHIFT_W-1:0]  w_word_pad;
    logic                w_slot_free;
    logic [CODE_W:1]     w_enc;

    ifns_rr_arb2 u_arb (
        .i_valid0      (bus.req0_valid),
        .i_valid1      (bus.req1_valid),
        .i_rr_last     (r_rr_last),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // Encoder only ever sees the registered shift register, so requester
    // data has no combinational path to the bus.
    encoderIFNS_5di_core u_enc (
        .i_data (r_shift[CHUNK_W-1:0]),
        .o_code (w_enc)
    );

    // Handshake depends only on state and valids, never on code_ready.
    assign w_idle      = (r_state == IDLE) && !rst;
    assign w_ready0    = w_idle && w_grant_valid && (w_grant == 1'b0);
    assign w_ready1    = w_idle && w_grant_valid && (w_grant == 1'b1);
    assign w_accept    = w_ready0 | w_ready1;
    assign w_word      = w_grant ? bus.req1_data : bus.req0_data;
    assign w_slot_free = !r_code_valid || bus.code_ready;

    // Zero-extend the word to a whole number of chunks.
    always_comb begin
        w_word_pad               = '0;
        w_word_pad[DATA_W-1:0]   = w_word;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_chunk_idx  <= '0;
            r_src        <= 1'b0;
            r_rr_last    <= 1'b1;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_code_sof   <= 1'b0;
            r_code_eof   <= 1'b0;
            r_code_src   <= 1'b0;
        end else begin
            // A consumed (or empty) slot goes invalid unless reloaded below.
            // r_code is deliberately left alone so the bus does not toggle.
            if (w_slot_free) begin
                r_code_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift     <= w_word_pad;
                        r_src       <= w_grant;
                        r_rr_last   <= w_grant;
                        r_chunk_idx <= '0;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    if (w_slot_free) begin
                        r_code       <= w_enc;
                        r_code_valid <= 1'b1;
                        r_code_sof   <= (r_chunk_idx == '0);
                        r_code_eof   <= (r_chunk_idx == c_LAST_IDX);
                        r_code_src   <= r_src;
                        r_shift      <= r_shift >> CHUNK_W;
                        r_chunk_idx  <= r_chunk_idx + CIDX_W'(1);
                        if (r_chunk_idx == c_LAST_IDX) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.code_out   = r_code;
    assign bus.code_valid = r_code_valid;
    assign bus.code_sof   = r_code_sof;
    assign bus.code_eof   = r_code_eof;
    assign bus.code_src   = r_code_src;

endmodule
`default_nettype wire

// File: tb/tb_ifns_link_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifns_link_scheduler
//  Description : Directed self-checking bench for ifns_link_scheduler
//                (DATA_W=20 instance plus a DATA_W=7 instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifns_link_scheduler;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    ifns_link_scheduler_if #(.DATA_W(20)) bus  ();
    ifns_link_scheduler_if #(.DATA_W(7))  bus7 ();

    ifns_link_scheduler #(.DATA_W(20)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    ifns_link_scheduler #(.DATA_W(7)) dut7 (
        .clock (clock),
        .rst   (rst),
        .bus   (bus7)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Hand-computed codeword table (greedy weights 13,8,5,3,2,1,1 on d7..d1).
    function automatic logic [6:0] enc_ref(input logic [4:0] v);
        case (v)
            5'd0:  return 7'h00;  5'd1:  return 7'h02;  5'd2:  return 7'h04;
            5'd3:  return 7'h08;  5'd4:  return 7'h0A;  5'd5:  return 7'h10;
            5'd6:  return 7'h12;  5'd7:  return 7'h14;  5'd8:  return 7'h20;
            5'd9:  return 7'h22;  5'd10: return 7'h24;  5'd11: return 7'h28;
            5'd12: return 7'h2A;  5'd13: return 7'h40;  5'd14: return 7'h42;
            5'd15: return 7'h44;  5'd16: return 7'h48;  5'd17: return 7'h4A;
            5'd18: return 7'h50;  5'd19: return 7'h52;  5'd20: return 7'h54;
            5'd21: return 7'h60;  5'd22: return 7'h62;  5'd23: return 7'h64;
            5'd24: return 7'h68;  5'd25: return 7'h6A;  5'd26: return 7'h70;
            5'd27: return 7'h72;  5'd28: return 7'h74;  5'd29: return 7'h78;
            5'd30: return 7'h7A;  default: return 7'h7C;
        endcase
    endfunction

    // Expected {code, sof, eof, src} for chunk k of a 20-bit word.
    function automatic logic [9:0] exp_cw(input logic src, input logic [19:0] data, input int k);
        logic [19:0] t;
        t = data >> (5 * k);
        return {enc_ref(t[4:0]), (k == 0), (k == 3), src};
    endfunction

    function automatic logic [9:0] obs_cw();
        return {bus.code_out, bus.code_sof, bus.code_eof, bus.code_src};
    endfunction

    // Called at the negedge where chunk 0 is presented; returns at the
    // negedge following chunk 3.
    task automatic check_word(input string tag, input logic src, input logic [19:0] data);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_valid"}, 32'(bus.code_valid), 32'd1);
            chk({tag, "_cw"}, 32'(obs_cw()), 32'(exp_cw(src, data, k)));
            @(negedge clock);
        end
    endtask

    logic [19:0] d0 [4];
    logic [19:0] d1 [4];
    logic [9:0]  exp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  e;
        logic [9:0]  hold_cw;
        logic [6:0]  hold_code;
        logic        a0, a1;
        int          cnt0, cnt1, nw, c;

        d0[0] = 20'h12345; d0[1] = 20'hFEDCB; d0[2] = 20'h0F0F0; d0[3] = 20'h80001;
        d1[0] = 20'h54321; d1[1] = 20'hAAAAA; d1[2] = 20'h55555; d1[3] = 20'hFFFFF;

        bus.req0_data  = '0; bus.req0_valid  = 1'b1;
        bus.req1_data  = '0; bus.req1_valid  = 1'b0;
        bus.code_ready = 1'b1;
        bus7.req0_data = '0; bus7.req0_valid = 1'b0;
        bus7.req1_data = '0; bus7.req1_valid = 1'b0;
        bus7.code_ready = 1'b1;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_code",  32'(bus.code_out),   32'h0);
        chk("rst_valid", 32'(bus.code_valid), 32'h0);
        chk("rst_sof",   32'(bus.code_sof),   32'h0);
        chk("rst_eof",   32'(bus.code_eof),   32'h0);
        chk("rst_src",   32'(bus.code_src),   32'h0);
        chk("rst_rdy0",  32'(bus.req0_ready), 32'h0);

        // ---------------- single word ----------------
        bus.req0_data = 20'hABCDE;
        rst = 1'b0;
        #1;
        chk("sw_rdy0", 32'(bus.req0_ready), 32'h1);
        chk("sw_rdy1", 32'(bus.req1_ready), 32'h0);
        @(negedge clock);
        chk("sw_latency", 32'(bus.code_valid), 32'h0);
        chk("sw_rdy_send", 32'(bus.req0_ready), 32'h0);
        bus.req0_valid = 1'b0;
        @(negedge clock);
        chk("sw_c0", 32'(obs_cw()), 32'({7'h7A, 1'b1, 1'b0, 1'b0}));
        check_word("sw", 1'b0, 20'hABCDE);
        chk("sw_idle_valid", 32'(bus.code_valid), 32'h0);
        chk("sw_idle_hold",  32'(bus.code_out),   32'h60);

        // ---------------- fairness ----------------
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        cnt0 = 0; cnt1 = 0; nw = 0; c = -1;
        bus.req0_data = d0[0]; bus.req0_valid = 1'b1;
        bus.req1_data = d1[0]; bus.req1_valid = 1'b1;
        #1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (bus.code_valid && c < 0) c = 0;
            if (c >= 0) chk("fair_valid", 32'(bus.code_valid), 32'((c % 5) != 4));
            if (bus.code_valid) begin
                if (exp_q.size() == 0) begin
                    chk("fair_extra", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("fair_cw", 32'(obs_cw()), 32'(e));
                end
            end
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            if (a0 || a1) begin
                chk("fair_grant", 32'(a1), 32'(nw % 2));
                for (int k = 0; k < 4; k++)
                    exp_q.push_back(exp_cw(1'(nw % 2), (nw % 2 == 1) ? d1[cnt1] : d0[cnt0], k));
                nw++;
            end
            if (c >= 0) c++;
            if (c >= 40) break;
            @(posedge clock);
            #1;
            if (a0) begin
                cnt0++;
                if (cnt0 < 4) bus.req0_data = d0[cnt0]; else bus.req0_valid = 1'b0;
            end
            if (a1) begin
                cnt1++;
                if (cnt1 < 4) bus.req1_data = d1[cnt1]; else bus.req1_valid = 1'b0;
            end
            @(negedge clock);
        end
        chk("fair_words", 32'(nw), 32'd8);
        chk("fair_drain", 32'(exp_q.size()), 32'd0);
        chk("fair_ended", 32'(c), 32'd40);

        // ---------------- backpressure ----------------
        @(negedge clock);
        bus.req1_data = 20'h76A39; bus.req1_valid = 1'b1;
        @(negedge clock);
        bus.req1_valid = 1'b0;
        @(negedge clock);
        chk("bp_c0", 32'(obs_cw()), 32'(exp_cw(1'b1, 20'h76A39, 0)));
        @(negedge clock);
        chk("bp_c1", 32'(obs_cw()), 32'(exp_cw(1'b1, 20'h76A39, 1)));
        bus.code_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 20'h11111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_hold_valid", 32'(bus.code_valid), 32'h1);
            chk("bp_hold_cw",    32'(obs_cw()), 32'(exp_cw(1'b1, 20'h76A39, 1)));
            chk("bp_rdy0",       32'(bus.req0_ready), 32'h0);
            chk("bp_rdy1",       32'(bus.req1_ready), 32'h0);
        end
        bus.code_ready = 1'b1;
        bus.req0_valid = 1'b0;
        @(negedge clock);
        chk("bp_c2", 32'(obs_cw()), 32'(exp_cw(1'b1, 20'h76A39, 2)));
        @(negedge clock);
        chk("bp_c3", 32'(obs_cw()), 32'(exp_cw(1'b1, 20'h76A39, 3)));
        @(negedge clock);
        chk("bp_end_valid", 32'(bus.code_valid), 32'h0);

        // ---------------- reset mid-word ----------------
        bus.req0_data = 20'h13579; bus.req0_valid = 1'b1;
        @(negedge clock);
        bus.req0_valid = 1'b0;
        @(negedge clock);
        chk("mr_c0", 32'(obs_cw()), 32'(exp_cw(1'b0, 20'h13579, 0)));
        @(negedge clock);
        @(negedge clock);
        chk("mr_c2", 32'(obs_cw()), 32'(exp_cw(1'b0, 20'h13579, 2)));
        rst = 1'b1;
        bus.req0_data = 20'h2468A; bus.req0_valid = 1'b1;
        bus.req1_data = 20'hFFFFF; bus.req1_valid = 1'b1;
        @(negedge clock);
        chk("mr_code",  32'(bus.code_out),   32'h0);
        chk("mr_valid", 32'(bus.code_valid), 32'h0);
        chk("mr_sof",   32'(bus.code_sof),   32'h0);
        chk("mr_eof",   32'(bus.code_eof),   32'h0);
        chk("mr_src",   32'(bus.code_src),   32'h0);
        chk("mr_rdy0_rst", 32'(bus.req0_ready), 32'h0);
        chk("mr_rdy1_rst", 32'(bus.req1_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("mr_rdy0_tie", 32'(bus.req0_ready), 32'h1);
        chk("mr_rdy1_tie", 32'(bus.req1_ready), 32'h0);
        @(negedge clock);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clock);
        check_word("mr", 1'b0, 20'h2468A);
        chk("mr_end_valid", 32'(bus.code_valid), 32'h0);

        // ---------------- idle hold ----------------
        hold_cw   = exp_cw(1'b0, 20'h2468A, 3);
        hold_code = hold_cw[9:3];
        for (int i = 0; i < 10; i++) begin
            bus.req0_data = 20'($urandom);
            bus.req1_data = 20'($urandom);
            @(negedge clock);
            chk("ih_code", 32'(bus.code_out),   32'(hold_code));
            chk("ih_rdy0", 32'(bus.req0_ready), 32'h0);
            chk("ih_rdy1", 32'(bus.req1_ready), 32'h0);
        end

        // ---------------- DATA_W = 7 ----------------
        bus7.req0_data = 7'h7F; bus7.req0_valid = 1'b1;
        @(negedge clock);
        bus7.req0_valid = 1'b0;
        @(negedge clock);
        chk("w7_c0", 32'({bus7.code_valid, bus7.code_out, bus7.code_sof, bus7.code_eof, bus7.code_src}),
                     32'({1'b1, 7'h7C, 1'b1, 1'b0, 1'b0}));
        @(negedge clock);
        chk("w7_c1", 32'({bus7.code_valid, bus7.code_out, bus7.code_sof, bus7.code_eof, bus7.code_src}),
                     32'({1'b1, 7'h08, 1'b0, 1'b1, 1'b0}));
        @(negedge clock);
        chk("w7_end", 32'({bus7.code_valid, bus7.code_out}), 32'({1'b0, 7'h08}));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
